ped_request_ltc: RTL and testbench



---
 rtl/ltc_pkg.sv | 12 +
 rtl/ped_debounce.sv | 26 ++
 rtl/ped_request_ltc.sv | 80 ++++++++
 tb/tb_ped_request_ltc.sv | 130 +++++++++++++
 4 files changed

// File: rtl/ltc_pkg.sv
// ltc_pkg: state encoding and {J,P,C} light codes shared by the traffic light controllers
package ltc_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WALK    = 2'd2,
    LOCKOUT = 2'd3
  } ped_state_t;
  localparam logic [2:0] GREEN  = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b001;
endpackage

// File: rtl/ped_debounce.sv
// ped_debounce: two-flop synchronizer plus saturating debounce counter giving a one-cycle press pulse
module ped_debounce #(
  parameter int DEB_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic req_pulse
);
  localparam int W = $clog2(DEB_CYC + 1);
  logic [1:0] sync;
  logic [W-1:0] cnt;
  logic btn_s;
  assign btn_s = sync[1];
  // counter saturates at DEB_CYC so a held button yields a single pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync      <= '0;
      cnt       <= '0;
      req_pulse <= 1'b0;
    end else begin
      sync      <= {sync[0], btn};
      cnt       <= !btn_s ? '0 : (cnt == W'(DEB_CYC)) ? cnt : cnt + W'(1);
      req_pulse <= btn_s && cnt == W'(DEB_CYC - 1);
    end
endmodule

// File: rtl/ped_request_ltc.sv
// ped_request_ltc: pedestrian request, walk phase and lockout sequencing alongside main_ltc
module ped_request_ltc
  import ltc_pkg::*;
#(
  parameter int DEB_CYC  = 3,
  parameter int WALK_CYC = 10,
  parameter int LOCK_CYC = 20,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             J,
  input  logic             P,
  input  logic             C,
  output logic             N,
  output logic             walk,
  output logic             dont_walk,
  output logic             wait_lamp,
  output logic [CNT_W-1:0] walk_cnt
);
  localparam int LK_W = $clog2(LOCK_CYC + 2);
  localparam ped_state_t DONE = (LOCK_CYC == 0) ? IDLE : LOCKOUT;
  ped_state_t state, state_n;
  logic [CNT_W-1:0] cnt_n;
  logic [LK_W-1:0] lock_cnt, lock_n;
  logic req_pulse, red;
  ped_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .req_pulse (req_pulse)
  );
  assign red = {J, P, C} == RED;
  // loss of red aborts the walk ahead of the normal countdown exit
  always_comb begin
    state_n = state;
    cnt_n   = walk_cnt;
    lock_n  = lock_cnt;
    case (state)
      IDLE: state_n = req_pulse ? REQ : IDLE;
      REQ:
        if (red) begin
          state_n = WALK;
          cnt_n   = CNT_W'(WALK_CYC);
        end
      WALK:
        if (!red || walk_cnt == CNT_W'(1)) begin
          state_n = DONE;
          cnt_n   = '0;
          lock_n  = LK_W'(LOCK_CYC);
        end else
          cnt_n = walk_cnt - CNT_W'(1);
      default:
        if (lock_cnt <= LK_W'(1))
          state_n = IDLE;
        else
          lock_n = lock_cnt - LK_W'(1);
    endcase
  end
  // lamps are registered straight from the next state so they change with the state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      walk_cnt  <= '0;
      N         <= 1'b0;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      wait_lamp <= 1'b0;
    end else begin
      state     <= state_n;
      lock_cnt  <= lock_n;
      walk_cnt  <= cnt_n;
      N         <= state_n == REQ;
      wait_lamp <= state_n == REQ;
      walk      <= state_n == WALK;
      dont_walk <= state_n != WALK;
    end
endmodule

// File: tb/tb_ped_request_ltc.sv
// tb_ped_request_ltc: segment-table stimulus with a queued expected-output scoreboard
module tb_ped_request_ltc;
  typedef struct packed {
    logic       n;
    logic       walk;
    logic       dw;
    logic       wl;
    logic [4:0] cnt;
  } exp_t;
  typedef struct {
    int         len;
    logic       b;
    logic [2:0] jpc;
    int         ph;
    int         cnt;
  } seg_t;
  localparam logic [2:0] GRN = 3'b100, YEL = 3'b010, RD = 3'b001;
  logic clk = 1'b0, rst = 1'b0, btn = 1'b0, J = 1'b0, P = 1'b0, C = 1'b0;
  logic N, walk, dont_walk, wait_lamp;
  logic [4:0] walk_cnt;
  int checks = 0, passed = 0;
  exp_t q[$];
  seg_t tbl[$], tbl2[$];
  ped_request_ltc dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .J         (J),
    .P         (P),
    .C         (C),
    .N         (N),
    .walk      (walk),
    .dont_walk (dont_walk),
    .wait_lamp (wait_lamp),
    .walk_cnt  (walk_cnt)
  );
  always #5 clk = ~clk;
  // ph: 0 idle/lockout, 1 request pending, 2 walking with countdown cnt
  function automatic exp_t ph_exp(int ph, int cnt);
    exp_t e;
    e.n    = ph == 1;
    e.walk = ph == 2;
    e.dw   = ph != 2;
    e.wl   = ph == 1;
    e.cnt  = ph == 2 ? 5'(cnt) : 5'd0;
    return e;
  endfunction
  function automatic seg_t mk(int len, logic b, logic [2:0] jpc, int ph, int cnt);
    return '{len, b, jpc, ph, cnt};
  endfunction
  task automatic compare(string nm);
    exp_t e, a;
    e = q.pop_front();
    a = {N, walk, dont_walk, wait_lamp, walk_cnt};
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got N=%b walk=%b dont_walk=%b wait=%b cnt=%0d, want N=%b walk=%b dont_walk=%b wait=%b cnt=%0d",
                  nm, a.n, a.walk, a.dw, a.wl, a.cnt, e.n, e.walk, e.dw, e.wl, e.cnt);
  endtask
  task automatic expect_now(string nm, exp_t e);
    q.push_back(e);
    compare(nm);
  endtask
  task automatic step(logic b, logic [2:0] jpc, exp_t e, string nm);
    btn = b;
    {J, P, C} = jpc;
    q.push_back(e);
    @(posedge clk);
    #1;
    compare(nm);
  endtask
  task automatic run(seg_t t[$], string tag);
    for (int s = 0; s < t.size(); s++)
      for (int i = 0; i < t[s].len; i++)
        step(t[s].b, t[s].jpc, ph_exp(t[s].ph, t[s].cnt - i), $sformatf("%s_seg%0d_cyc%0d", tag, s, i));
  endtask
  initial begin
    // bounce: 2 high, 1 low, 2 high, then low long enough to clear
    tbl.push_back(mk(2, 1, RD, 0, 0));
    tbl.push_back(mk(1, 0, RD, 0, 0));
    tbl.push_back(mk(2, 1, RD, 0, 0));
    tbl.push_back(mk(3, 0, RD, 0, 0));
    // normal service, re-press in lockout, press held across return to idle, fresh press
    tbl.push_back(mk(5, 1, RD, 0, 0));
    tbl.push_back(mk(1, 0, RD, 1, 0));
    tbl.push_back(mk(10, 0, RD, 2, 10));
    tbl.push_back(mk(3, 0, RD, 0, 0));
    tbl.push_back(mk(5, 1, RD, 0, 0));
    tbl.push_back(mk(7, 0, RD, 0, 0));
    tbl.push_back(mk(9, 1, RD, 0, 0));
    tbl.push_back(mk(2, 0, RD, 0, 0));
    tbl.push_back(mk(5, 1, RD, 0, 0));
    tbl.push_back(mk(1, 0, RD, 1, 0));
    // waiting for red, including non-one-hot light codes
    tbl.push_back(mk(8, 0, GRN, 1, 0));
    tbl.push_back(mk(3, 0, YEL, 1, 0));
    tbl.push_back(mk(1, 0, 3'b101, 1, 0));
    tbl.push_back(mk(1, 0, 3'b011, 1, 0));
    tbl.push_back(mk(1, 0, 3'b000, 1, 0));
    tbl.push_back(mk(5, 0, RD, 2, 10));
    // abort at walk_cnt 6, then a press timed to land on the first idle cycle
    tbl.push_back(mk(1, 0, GRN, 0, 0));
    tbl.push_back(mk(15, 0, GRN, 0, 0));
    tbl.push_back(mk(5, 1, RD, 0, 0));
    tbl.push_back(mk(1, 0, RD, 1, 0));
    tbl.push_back(mk(7, 0, RD, 2, 10));
    // after the mid-walk reset
    tbl2.push_back(mk(5, 1, RD, 0, 0));
    tbl2.push_back(mk(1, 0, RD, 1, 0));
    tbl2.push_back(mk(2, 0, RD, 2, 10));
    btn = 1'b1;
    J = 1'b1;
    #1 rst = 1'b1;
    #1 expect_now("reset_async", ph_exp(0, 0));
    @(posedge clk);
    #1 expect_now("reset_held", ph_exp(0, 0));
    rst = 1'b0;
    run(tbl, "main");
    #2 rst = 1'b1;
    btn = 1'b1;
    #1 expect_now("reset_mid_walk", ph_exp(0, 0));
    @(posedge clk);
    #1 expect_now("reset_mid_walk_held", ph_exp(0, 0));
    rst = 1'b0;
    btn = 1'b0;
    run(tbl2, "post_reset");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
